// File: rtl/imem_uart_loader.sv
// UART boot loader: receives A5/LEN/words[/CSUM] frames, writes words into instruction memory
// and releases the core from reset once a full image is in. Optional checksum: LOADER_CHECKSUM_EN.
module imem_uart_loader #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int MAX_WORDS   = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rx,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_resetn,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_WAIT_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    // ---------------- receiver ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ferr_q, rx_ferr_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rx_sync_q;
                    rx_ferr_d  = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- frame FSM ----------------
    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        cpu_resetn_q, cpu_resetn_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic [15:0] len_full;
    logic [31:0] word_full;
    assign len_full  = {rx_shift_q, len_q[7:0]};
    assign word_full = {rx_shift_q, word_q[31:8]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_WAIT_SYNC;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            cpu_resetn_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            cpu_resetn_q <= cpu_resetn_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (reload) begin
            state_d    = S_WAIT_SYNC;
            len_d      = '0;
            word_idx_d = '0;
            byte_idx_d = '0;
            word_d     = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
        end else if (rx_ferr_q && state_q != S_DONE) begin
            state_d = S_ERROR;
        end else if (rx_valid_q) begin
            case (state_q)
                S_WAIT_SYNC: begin
                    if (rx_shift_q == 8'hA5) begin
                        state_d    = S_LEN_LO;
                        word_idx_d = '0;
                        byte_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = '0;
`endif
                    end
                end
                S_LEN_LO: begin
                    len_d   = {8'h00, rx_shift_q};
                    state_d = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d = len_full;
                    if (len_full > 16'(MAX_WORDS)) state_d = S_ERROR;
                    else if (len_full == 16'd0)    state_d = S_AFTER_DATA;
                    else                           state_d = S_DATA;
                end
                S_DATA: begin
                    // Little-endian: each new byte enters at the top and slides down.
                    word_d     = word_full;
                    byte_idx_d = byte_idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_shift_q;
`endif
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = word_full;
                        waddr_d    = {14'd0, word_idx_q, 2'b00};
                        word_idx_d = word_idx_q + 16'd1;
                        if (word_idx_q == len_q - 16'd1) state_d = S_AFTER_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: state_d = (rx_shift_q == csum_q) ? S_DONE : S_ERROR;
`endif
                default: ;
            endcase
        end
        // Core leaves reset one cycle after DONE is entered and drops as soon as DONE is left.
        cpu_resetn_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_resetn = cpu_resetn_q;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign busy       = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);

endmodule
